// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: ALU op codes,
// FSM state encoding and small op-class helpers.
package muldiv_unit_pkg;

  localparam logic [5:0] OP_ALU_MUL  = 6'h20;
  localparam logic [5:0] OP_ALU_MULH = 6'h21;
  localparam logic [5:0] OP_ALU_DIV  = 6'h22;
  localparam logic [5:0] OP_ALU_DIVU = 6'h23;
  localparam logic [5:0] OP_ALU_REM  = 6'h24;
  localparam logic [5:0] OP_ALU_REMU = 6'h25;

  typedef enum logic [1:0] {
    MULDIV_ST_IDLE = 2'd0,
    MULDIV_ST_CALC = 2'd1,
    MULDIV_ST_DONE = 2'd2
  } muldiv_st_e;

  function automatic logic is_m_op(input logic [5:0] op);
    return op inside {OP_ALU_MUL, OP_ALU_MULH, OP_ALU_DIV, OP_ALU_DIVU, OP_ALU_REM, OP_ALU_REMU};
  endfunction

  function automatic logic is_mul_op(input logic [5:0] op);
    return op inside {OP_ALU_MUL, OP_ALU_MULH};
  endfunction

  // Ops that work on magnitudes and fix the sign up afterwards
  function automatic logic is_signed_op(input logic [5:0] op);
    return op inside {OP_ALU_MULH, OP_ALU_DIV, OP_ALU_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_div_restoring_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference and shift in a 1 when it does not borrow.
module div_restoring_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ge;

  // rem < divisor always holds, so the top bit of diff is a clean borrow flag
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign ge      = ~diff[XLEN];
  assign rem_nxt = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], ge};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit (MUL/MULH/DIV/DIVU/REM/REMU), one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: MUL/MULH resolve in one cycle via a combinational multiply.
import muldiv_unit_pkg::*;

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [5:0]      i_alu_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 2);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_st_e state, state_nxt;

  logic [5:0]      op_q;
  logic            neg_q, rneg_q;
  logic [XLEN-1:0] hi_q, lo_q, d_q, result_q;
  logic [CW-1:0]   count_q;

  logic            accept, sa, sb, div0, ovf, special, fast_go;
  logic [XLEN-1:0] abs_a, abs_b, spec_res, fast_res, fin_res;

  assign accept = i_start & (state == MULDIV_ST_IDLE) & is_m_op(i_alu_op) & ~i_flush;
  assign sa     = i_op_a[XLEN-1];
  assign sb     = i_op_b[XLEN-1];
  assign abs_a  = (is_signed_op(i_alu_op) & sa) ? -i_op_a : i_op_a;
  assign abs_b  = (is_signed_op(i_alu_op) & sb) ? -i_op_b : i_op_b;

  assign div0    = (i_alu_op inside {OP_ALU_DIV, OP_ALU_DIVU, OP_ALU_REM, OP_ALU_REMU}) & (i_op_b == '0);
  assign ovf     = (i_alu_op inside {OP_ALU_DIV, OP_ALU_REM}) & (i_op_a == INT_MIN) & (&i_op_b);
  assign special = div0 | ovf;

  always_comb begin
    spec_res = '0;
    if (div0)
      spec_res = (i_alu_op inside {OP_ALU_DIV, OP_ALU_DIVU}) ? '1 : i_op_a;
    else if (i_alu_op == OP_ALU_DIV)
      spec_res = INT_MIN;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = $signed({{XLEN{sa}}, i_op_a}) * $signed({{XLEN{sb}}, i_op_b});
  assign fast_go   = is_mul_op(i_alu_op);
  assign fast_res  = (i_alu_op == OP_ALU_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_go  = 1'b0;
  assign fast_res = '0;
`endif

  // The first iteration is folded into the accept edge (step inputs come straight
  // from the operands while idle), so o_done lands XLEN cycles after acceptance.
  logic            st_mul;
  logic [XLEN-1:0] st_hi, st_lo, st_d;
  logic [XLEN:0]   msum;
  logic [XLEN-1:0] mhi_nxt, mlo_nxt, dhi_nxt, dlo_nxt, hi_nxt, lo_nxt;

  assign st_mul = (state == MULDIV_ST_IDLE) ? is_mul_op(i_alu_op) : is_mul_op(op_q);
  assign st_hi  = (state == MULDIV_ST_IDLE) ? '0    : hi_q;
  assign st_lo  = (state == MULDIV_ST_IDLE) ? abs_a : lo_q;
  assign st_d   = (state == MULDIV_ST_IDLE) ? abs_b : d_q;

  assign msum    = {1'b0, st_hi} + (st_lo[0] ? {1'b0, st_d} : '0);
  assign mhi_nxt = msum[XLEN:1];
  assign mlo_nxt = {msum[0], st_lo[XLEN-1:1]};

  div_restoring_step #(.XLEN(XLEN)) u_div_step (
    .rem     (st_hi),
    .quo     (st_lo),
    .divisor (st_d),
    .rem_nxt (dhi_nxt),
    .quo_nxt (dlo_nxt)
  );

  assign hi_nxt = st_mul ? mhi_nxt : dhi_nxt;
  assign lo_nxt = st_mul ? mlo_nxt : dlo_nxt;

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  assign prod   = {mhi_nxt, mlo_nxt};
  assign prod_s = neg_q  ? -prod    : prod;
  assign quo_s  = neg_q  ? -dlo_nxt : dlo_nxt;
  assign rem_s  = rneg_q ? -dhi_nxt : dhi_nxt;

  always_comb begin
    fin_res = '0;
    case (op_q)
      OP_ALU_MUL:               fin_res = prod_s[XLEN-1:0];
      OP_ALU_MULH:              fin_res = prod_s[2*XLEN-1:XLEN];
      OP_ALU_DIV, OP_ALU_DIVU:  fin_res = quo_s;
      OP_ALU_REM, OP_ALU_REMU:  fin_res = rem_s;
      default:                  fin_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= MULDIV_ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MULDIV_ST_IDLE:
        if (accept) state_nxt = (special | fast_go) ? MULDIV_ST_DONE : MULDIV_ST_CALC;
      MULDIV_ST_CALC:
        if (i_flush)               state_nxt = MULDIV_ST_IDLE;
        else if (count_q == LAST)  state_nxt = MULDIV_ST_DONE;
      MULDIV_ST_DONE:
        state_nxt = MULDIV_ST_IDLE;
      default:
        state_nxt = MULDIV_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      d_q      <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= i_alu_op;
      neg_q   <= is_signed_op(i_alu_op) & (sa ^ sb);
      rneg_q  <= is_signed_op(i_alu_op) & sa;
      d_q     <= abs_b;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
      count_q <= '0;
      if (special)      result_q <= spec_res;
      else if (fast_go) result_q <= fast_res;
    end else if (state == MULDIV_ST_CALC && !i_flush) begin
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
      count_q <= count_q + CW'(1);
      if (count_q == LAST) result_q <= fin_res;
    end
  end

  assign o_ready  = (state == MULDIV_ST_IDLE);
  assign o_busy   = (state == MULDIV_ST_CALC) | (state == MULDIV_ST_DONE);
  assign o_done   = (state == MULDIV_ST_DONE) & ~i_flush;
  assign o_result = result_q;

endmodule
